// File: rtl/s4_corr_buf_if.sv
// Beat stream bundle for the RS correction buffer: raw codeword beats in, corrected beats out.
interface s4_corr_buf_if #(
    parameter int unsigned DW = 64,
    parameter int unsigned SW = 12
);
    logic          in_valid;
    logic          in_sof;
    logic [DW-1:0] in_data;
    logic [SW-1:0] in_sync;
    logic          out_valid;
    logic          out_sof;
    logic          out_eof;
    logic [DW-1:0] out_data;
    logic [SW-1:0] out_sync;

    modport master (
        output in_valid, in_sof, in_data, in_sync,
        input  out_valid, out_sof, out_eof, out_data, out_sync
    );

    modport slave (
        input  in_valid, in_sof, in_data, in_sync,
        output out_valid, out_sof, out_eof, out_data, out_sync
    );
endinterface

// File: rtl/s4_corr_buf.sv
// RS decoder final stage: ping-pong codeword buffer, error-pattern correction and per-frame status.
// Optional RS_CORR_ERRCNT_EN adds corr_cnt, a saturating count of corrected nonzero bytes.
module s4_corr_buf #(
    parameter int unsigned BEATS = 24,
    parameter int unsigned DW    = 64,
    parameter int unsigned SW    = 12
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rs_ena,
    s4_corr_buf_if.slave  bus,
    input  logic          csee_ongo,
    input  logic [DW-1:0] rs_errdata,
    input  logic [SW-1:0] rs_syncbit,
    input  logic          rsdec_fail,
    output logic          dec_done,
    output logic          dec_fail,
    output logic          buf_ovf,
    output logic          buf_unf
`ifdef RS_CORR_ERRCNT_EN
    ,
    output logic [15:0]   corr_cnt
`endif
);
    localparam int unsigned CW = $clog2(BEATS);
    localparam int unsigned NB = DW / 8;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef struct packed {
        logic [1:0]    full;
        logic          wr_bank;
        logic          rd_bank;
        logic          wr_act;
        logic [CW-1:0] wcnt;
        logic [CW-1:0] rcnt;
        logic          st_p1;
        logic          st_p2;
        logic          out_valid;
        logic          out_sof;
        logic          out_eof;
        logic [DW-1:0] out_data;
        logic [SW-1:0] out_sync;
        logic          dec_done;
        logic          dec_fail;
        logic          buf_ovf;
        logic          buf_unf;
`ifdef RS_CORR_ERRCNT_EN
        logic [7:0]    acc;
        logic [7:0]    pend;
        logic [15:0]   corr_cnt;
`endif
    } ctl_t;

    ctl_t r, n;

    logic [DW-1:0] mem [0:1][0:BEATS-1];
    logic [SW-1:0] sync_mem [0:1];

    logic          wr_start_c, wr_beat_c, wr_en_c, wr_last_c, ovf_c, rd_last_c;
    logic [CW-1:0] wr_addr_c;

`ifdef RS_CORR_ERRCNT_EN
    logic [7:0]  acc_sum_c;
    logic [16:0] sum_c;

    function automatic logic [7:0] nz_bytes(input logic [DW-1:0] d);
        logic [7:0] c;
        c = 8'd0;
        for (int i = 0; i < int'(NB); i++) begin
            if (d[8*i +: 8] != 8'd0) c = c + 8'd1;
        end
        return c;
    endfunction
`endif

    // Next-state: write side, read/correct side, status pipeline.
    always_comb begin
        n          = r;
        ovf_c      = rs_ena & bus.in_valid & bus.in_sof & r.full[r.wr_bank];
        wr_start_c = rs_ena & bus.in_valid & bus.in_sof & ~r.full[r.wr_bank];
        wr_beat_c  = rs_ena & bus.in_valid & ~bus.in_sof & r.wr_act;
        wr_en_c    = wr_start_c | wr_beat_c;
        wr_addr_c  = wr_start_c ? '0 : r.wcnt;
        wr_last_c  = wr_en_c & (wr_addr_c == LAST);
        rd_last_c  = csee_ongo & (r.rcnt == LAST);
`ifdef RS_CORR_ERRCNT_EN
        acc_sum_c  = 8'd0;
        sum_c      = 17'd0;
`endif

        if (ovf_c) begin
            n.buf_ovf = 1'b1;
            n.wr_act  = 1'b0;
            n.wcnt    = '0;
        end else if (wr_en_c) begin
            if (wr_last_c) begin
                n.wcnt    = '0;
                n.wr_act  = 1'b0;
                n.wr_bank = ~r.wr_bank;
            end else begin
                n.wcnt   = CW'(wr_addr_c + 1'b1);
                n.wr_act = 1'b1;
            end
        end

        // A bank drained on its last read beat is released only after this edge.
        if (rd_last_c) n.full[r.rd_bank] = 1'b0;
        if (wr_last_c) n.full[r.wr_bank] = 1'b1;

        n.out_valid = csee_ongo;
        n.out_sof   = csee_ongo & (r.rcnt == '0);
        n.out_eof   = rd_last_c;
        n.out_data  = csee_ongo ? (mem[r.rd_bank][r.rcnt] ^ rs_errdata) : '0;
        n.out_sync  = (csee_ongo && r.rcnt == '0) ? (sync_mem[r.rd_bank] ^ rs_syncbit) : '0;
        if (csee_ongo) begin
            if (r.rcnt == '0 && !r.full[r.rd_bank]) n.buf_unf = 1'b1;
            if (rd_last_c) begin
                n.rcnt    = '0;
                n.rd_bank = ~r.rd_bank;
            end else begin
                n.rcnt = CW'(r.rcnt + 1'b1);
            end
        end

        // Fail verdict settles two cycles after the last CSEE cycle.
        n.st_p1    = rd_last_c;
        n.st_p2    = r.st_p1;
        n.dec_done = r.st_p2;
        if (r.st_p2) n.dec_fail = rsdec_fail;

`ifdef RS_CORR_ERRCNT_EN
        if (csee_ongo) begin
            acc_sum_c = ((r.rcnt == '0) ? 8'd0 : r.acc) + nz_bytes(rs_errdata);
            if (rd_last_c) n.pend = acc_sum_c;
            else           n.acc  = acc_sum_c;
        end
        if (r.st_p2 && !rsdec_fail) begin
            sum_c      = 17'(r.corr_cnt) + 17'(r.pend);
            n.corr_cnt = sum_c[16] ? 16'hFFFF : sum_c[15:0];
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        r <= '0;
        else if (!rs_ena) r <= '0;
        else              r <= n;
    end

    // Beat storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_c)    mem[r.wr_bank][wr_addr_c] <= bus.in_data;
        if (wr_start_c) sync_mem[r.wr_bank]       <= bus.in_sync;
    end

    assign bus.out_valid = r.out_valid;
    assign bus.out_sof   = r.out_sof;
    assign bus.out_eof   = r.out_eof;
    assign bus.out_data  = r.out_data;
    assign bus.out_sync  = r.out_sync;
    assign dec_done      = r.dec_done;
    assign dec_fail      = r.dec_fail;
    assign buf_ovf       = r.buf_ovf;
    assign buf_unf       = r.buf_unf;
`ifdef RS_CORR_ERRCNT_EN
    assign corr_cnt      = r.corr_cnt;
`endif
endmodule
